display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (≥ GUARD_CYCLES+2).
REQ-002 SHALL have parameter GUARD_CYCLES, default 16, blanked cycles at the start of each slot (≥1).
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  scan enable; low blanks the display and freezes scan state.
REQ-006 SHALL have port load_valid  input  1  requester offers a new display frame.
REQ-007 SHALL have port load_ready  output  1  controller can accept a frame.
REQ-008 SHALL have port y_value  input  8  ALU result; sampled on accept.
REQ-009 SHALL have port operation  input  4  opcode; sampled on accept.
REQ-010 SHALL have port anode  output  4  active-low digit select.
REQ-011 SHALL have port segs  output  7  active-low segments {g..a}.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at each slot-3-to-slot-0 wrap.

Function
REQ-013 Slot order SHALL be 0,1,2,3,0...; slot anodes 1110,1101,1011,0111; slot digits operation, 4'h0, y[3:0], y[7:4] from the committed frame.
REQ-014 FSM SHALL have states GUARD (anode 1111, segs 1111111) and SHOW (slot anode, decoded digit); each slot = GUARD_CYCLES cycles GUARD then REFRESH_DIV-GUARD_CYCLES cycles SHOW.
REQ-015 Cycle counter SHALL count 0..REFRESH_DIV-1 per slot; at REFRESH_DIV-1 it wraps to 0, slot increments mod 4, state returns to GUARD.
REQ-016 anode/segs SHALL be registered: values for counter value n appear on outputs one cycle later.
REQ-017 Decode SHALL be hex 0-F, standard common-anode patterns (0=1000000, 8=0000000, F=0001110).
REQ-018 Accept SHALL occur when load_valid && load_ready at a rising edge; y_value/operation captured into a pending register; load_ready low from next cycle.
REQ-019 Commit SHALL occur on the cycle slot 3 wraps to slot 0: pending copied to committed frame, pending cleared, load_ready high next cycle; committed frame never changes mid-frame.
REQ-020 Wrap with pending empty SHALL leave committed frame unchanged; frame_done still pulses.
REQ-021 load_valid during the commit cycle SHALL NOT be accepted (load_ready low); acceptance possible from the following cycle.
REQ-022 enable low SHALL force anode 1111, segs 1111111 (registered), hold counter/slot/state, suppress frame_done; accept handshake remains operational.
REQ-023 enable rising SHALL resume from the held counter/slot without restarting the frame.

Reset
REQ-024 reset SHALL set: anode 1111, segs 1111111, frame_done 0, load_ready 1, state GUARD, slot 0, counter 0, pending empty, committed frame all zero.
REQ-025 reset SHALL dominate enable and load_valid; reset mid-frame SHALL discard pending and committed data.
REQ-026 First cycle after reset deassertion SHALL behave as counter 0 of slot 0.

Structure
REQ-027 Shared package SHALL hold FSM state encoding, slot-to-anode constants, blank patterns (ANODE_OFF=1111, SEGS_OFF=1111111).
REQ-028 Hex decode SHALL be one combinational sub-module, hex_to_segs (4-bit in, 7-bit out).
REQ-029 Counter width SHALL be $clog2(REFRESH_DIV).

Verification (REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-030 Reset, enable=1, no load -> anode 1111 ×2, 1110 ×6 with segs 1000000, then 1101 slot; frame_done at cycle 32, period 32.
REQ-031 Accept y=8'hA5, op=4'h3 mid-slot 1 -> load_ready low; slots 2,3 still old digits; after wrap slot0 segs 0110000, slot2 0010010, slot3 0001000; load_ready high.
REQ-032 load_valid held high across commit cycle -> not accepted there; accepted next cycle; committed on following wrap.
REQ-033 enable low during SHOW slot 2 for 5 cycles -> outputs blank, counter held; on re-enable remaining SHOW cycles of slot 2 complete, frame period +5.
REQ-034 reset asserted with pending frame mid-slot 3 -> all REQ-024 values next cycle; pending frame never displayed.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding,
// per-slot anode patterns and the blanked output values.
package display_scan_controller_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [3:0] ANODE_OFF   = 4'b1111;
  localparam logic [6:0] SEGS_OFF    = 7'b1111111;

  localparam logic [3:0] ANODE_SLOT0 = 4'b1110;
  localparam logic [3:0] ANODE_SLOT1 = 4'b1101;
  localparam logic [3:0] ANODE_SLOT2 = 4'b1011;
  localparam logic [3:0] ANODE_SLOT3 = 4'b0111;

  function automatic logic [3:0] slot_anode(input logic [1:0] slot);
    case (slot)
      2'd0:    return ANODE_SLOT0;
      2'd1:    return ANODE_SLOT1;
      2'd2:    return ANODE_SLOT2;
      default: return ANODE_SLOT3;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_controller_hex_to_segs.sv
// Hex digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_segs
  import display_scan_controller_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves segs unassigned (no latch).
    segs = SEGS_OFF;
    case (hex)
      4'h0: segs = 7'b1000000;
      4'h1: segs = 7'b1111001;
      4'h2: segs = 7'b0100100;
      4'h3: segs = 7'b0110000;
      4'h4: segs = 7'b0011001;
      4'h5: segs = 7'b0010010;
      4'h6: segs = 7'b0000010;
      4'h7: segs = 7'b1111000;
      4'h8: segs = 7'b0000000;
      4'h9: segs = 7'b0010000;
      4'hA: segs = 7'b0001000;
      4'hB: segs = 7'b0000011;
      4'hC: segs = 7'b1000110;
      4'hD: segs = 7'b0100001;
      4'hE: segs = 7'b0000110;
      4'hF: segs = 7'b0001110;
      default: segs = SEGS_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner with a guard-blanked slot at each
// digit change and a double-buffered frame that only swaps at the frame wrap.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] y_value,
  input  logic [3:0] operation,
  output logic [3:0] anode,
  output logic [6:0] segs,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST       = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD_LAST = CW'(GUARD_CYCLES - 1);

  scan_state_e   state;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic          pend_valid;
  logic [7:0]    pend_y, frame_y;
  logic [3:0]    pend_op, frame_op;
  logic [3:0]    digit;
  logic [6:0]    digit_segs;
  logic          slot_last, wrap, accept;

  assign slot_last  = (cnt == CNT_LAST);
  assign wrap       = enable && slot_last && (slot == 2'd3);
  assign load_ready = !pend_valid;
  assign accept     = load_valid && load_ready;

  always_comb begin
    digit = frame_op;
    case (slot)
      2'd0:    digit = frame_op;
      2'd1:    digit = 4'h0;
      2'd2:    digit = frame_y[3:0];
      default: digit = frame_y[7:4];
    endcase
  end

  hex_to_segs u_hex_to_segs (
    .hex  (digit),
    .segs (digit_segs)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values of one another.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_GUARD;
      cnt        <= '0;
      slot       <= 2'd0;
      pend_valid <= 1'b0;
      pend_y     <= '0;
      pend_op    <= '0;
      frame_y    <= '0;
      frame_op   <= '0;
      anode      <= ANODE_OFF;
      segs       <= SEGS_OFF;
      frame_done <= 1'b0;
    end else begin
      // Accept and commit are mutually exclusive: one needs pending empty, the other full.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_y     <= y_value;
        pend_op    <= operation;
      end else if (wrap && pend_valid) begin
        frame_y    <= pend_y;
        frame_op   <= pend_op;
        pend_valid <= 1'b0;
        pend_y     <= '0;
        pend_op    <= '0;
      end

      frame_done <= wrap;

      if (enable) begin
        if (slot_last) begin
          cnt   <= '0;
          slot  <= slot + 2'd1;
          state <= ST_GUARD;
        end else begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_GUARD_LAST) state <= ST_SHOW;
        end
      end

      if (enable && state == ST_SHOW) begin
        anode <= slot_anode(slot);
        segs  <= digit_segs;
      end else begin
        anode <= ANODE_OFF;
        segs  <= SEGS_OFF;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a cycle model pushes the expected post-edge outputs, which
// are popped and compared one time unit after each rising edge.
module tb_display_scan_controller;

  localparam int D = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset, enable, load_valid, load_ready, frame_done;
  logic [7:0] y_value;
  logic [3:0] operation, anode;
  logic [6:0] segs;

  always #5 clk = ~clk;

  display_scan_controller #(.REFRESH_DIV(D), .GUARD_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .y_value    (y_value),
    .operation  (operation),
    .anode      (anode),
    .segs       (segs),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] segs;
    logic       frame_done;
    logic       load_ready;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int         m_cnt, m_slot;
  logic       m_pend;
  logic [7:0] m_py, m_fy;
  logic [3:0] m_pop, m_fop;

  int cyc = 0, first_fd = 0, last_fd = 0, prev_fd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(output obs_t e);
    logic [3:0] dg;
    if (reset) begin
      m_cnt = 0; m_slot = 0; m_pend = 1'b0;
      m_py = '0; m_pop = '0; m_fy = '0; m_fop = '0;
      e.anode = 4'b1111; e.segs = 7'b1111111; e.frame_done = 1'b0; e.load_ready = 1'b1;
    end else begin
      case (m_slot)
        0:       dg = m_fop;
        1:       dg = 4'h0;
        2:       dg = m_fy[3:0];
        default: dg = m_fy[7:4];
      endcase
      if (enable && m_cnt >= G) begin
        e.anode = ~(4'(4'b0001 << m_slot));
        e.segs  = seg_tab[dg];
      end else begin
        e.anode = 4'b1111;
        e.segs  = 7'b1111111;
      end
      e.frame_done = enable && (m_cnt == D - 1) && (m_slot == 3);
      if (load_valid && !m_pend) begin
        m_pend = 1'b1; m_py = y_value; m_pop = operation;
      end else if (e.frame_done && m_pend) begin
        m_fy = m_py; m_fop = m_pop; m_pend = 1'b0;
      end
      if (enable) begin
        if (m_cnt == D - 1) begin
          m_cnt = 0;
          m_slot = (m_slot + 1) % 4;
        end else begin
          m_cnt++;
        end
      end
      e.load_ready = !m_pend;
    end
  endtask

  task automatic step();
    obs_t e, x;
    model(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check("anode", 32'(anode), 32'(x.anode));
    check("segs", 32'(segs), 32'(x.segs));
    check("frame_done", 32'(frame_done), 32'(x.frame_done));
    check("load_ready", 32'(load_ready), 32'(x.load_ready));
    if (reset) begin
      cyc = 0;
    end else begin
      cyc++;
      if (frame_done) begin
        if (first_fd == 0) first_fd = cyc;
        prev_fd = last_fd;
        last_fd = cyc;
      end
    end
  endtask

  task automatic wait_for(input int s, input int c);
    int budget = 200;
    while (!(m_slot == s && m_cnt == c)) begin
      if (budget == 0) begin
        check("wait_timeout", 32'd1, 32'd0);
        return;
      end
      budget--;
      step();
    end
  endtask

  int fd_before;

  initial begin
    reset = 1'b1; enable = 1'b1; load_valid = 1'b0; y_value = '0; operation = '0;
    repeat (2) step();
    reset = 1'b0;

    // Idle scan from reset: first wrap and steady frame period.
    repeat (70) step();
    check("first_frame_done_cycle", 32'(first_fd), 32'd32);
    check("frame_period", 32'(last_fd - prev_fd), 32'd32);

    // Accept mid-slot 1; new digits only after the next wrap.
    wait_for(1, 4);
    load_valid = 1'b1; y_value = 8'hA5; operation = 4'h3;
    step();
    load_valid = 1'b0;
    check("ready_low_after_accept", 32'(load_ready), 32'd0);
    repeat (70) step();

    // Valid held across the commit cycle: refused there, accepted next cycle.
    wait_for(1, 4);
    load_valid = 1'b1; y_value = 8'h12; operation = 4'h1;
    step();
    load_valid = 1'b0;
    wait_for(3, 4);
    load_valid = 1'b1; y_value = 8'h3C; operation = 4'h7;
    repeat (6) step();
    load_valid = 1'b0;
    check("ready_low_after_late_accept", 32'(load_ready), 32'd0);
    repeat (70) step();

    // Enable low for 5 cycles inside SHOW of slot 2 stretches the frame by 5.
    wait_for(2, 4);
    fd_before = last_fd;
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (20) step();
    check("paused_frame_period", 32'(last_fd - fd_before), 32'd37);
    repeat (30) step();

    // Reset with a pending frame mid-slot 3 discards it.
    wait_for(1, 4);
    load_valid = 1'b1; y_value = 8'hFF; operation = 4'hE;
    step();
    load_valid = 1'b0;
    wait_for(3, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_anode", 32'(anode), 32'hF);
    check("reset_segs", 32'(segs), 32'h7F);
    check("reset_ready", 32'(load_ready), 32'd1);
    repeat (70) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
